// File: rtl/trig_line_scheduler.sv
// rtl/trig_line_scheduler.sv - arbitrates the shared trigger line between booked lv1 pulses and plv1 pulses
module trig_line_scheduler #(
   parameter int SCHED   = 256,
   parameter int LV1_W   = 4,
   parameter int PLV1_W  = 3,
   parameter int GUARD   = 2,
   parameter int MIN_DLY = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_live,
   input  logic        in_plv1,
   input  logic        in_lv1_req,
   input  logic [7:0]  cfg_lv1_delay,
   output logic        out_lv1_ack,
   output logic        out_lv1_nack,
   output logic        out_lv1_inhibit,
   output logic        out_line,
   output logic        out_line_lv1,
   output logic [31:0] lv1_rej_cnt,
   output logic [31:0] plv1_drop_cnt,
   output logic        cfg_err,
   output logic        line_conflict
);

   localparam int SPAN = LV1_W + GUARD;
   localparam int LOOK = PLV1_W + GUARD;
   localparam int IW   = $clog2(SCHED);
   localparam int CW   = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_PLV1, ST_LV1, ST_GUARD} state_t;

   // sched[k] set means an lv1 start is due k+1 cycles from now, so the FSM
   // can enter LV1 on the very edge at which the pulse must appear.
   logic [SCHED-1:0] sched, sched_nxt;
   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             plv1_q, live_q;
   logic             start, rise, bad_dly, collide, accept, reject, live_clr;
   logic [1:0]       drop_inc;
   logic [IW-1:0]    book_idx;
   int               d;

   always_comb begin
      d        = int'(cfg_lv1_delay);
      bad_dly  = (d < MIN_DLY) || (d >= SCHED);
      collide  = 1'b0;
      for (int k = 0; k < SCHED; k++) begin
         if (sched[k] && (k >= d - SPAN - 1) && (k <= d + SPAN - 1))
            collide = 1'b1;
      end
      accept   = in_live && in_lv1_req && !bad_dly && !collide;
      reject   = in_live && in_lv1_req && (bad_dly || collide);
      book_idx = IW'(cfg_lv1_delay - 8'd2);
      sched_nxt = sched >> 1;
      if (accept)
         sched_nxt[book_idx] = 1'b1;
   end

   assign start    = sched[0];
   assign rise     = in_plv1 && !plv1_q;
   assign live_clr = in_live && !live_q;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
      drop_inc  = 2'd0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LV1;
               cnt_nxt   = CW'(LV1_W - 1);
               if (rise) drop_inc = 2'd1;
            end else if (rise) begin
               state_nxt = ST_PLV1;
               cnt_nxt   = CW'(PLV1_W - 1);
            end
         end
         ST_PLV1: begin
            if (start) begin
               state_nxt = ST_LV1;
               cnt_nxt   = CW'(LV1_W - 1);
               if (cnt != '0) drop_inc = drop_inc + 2'd1;
            end else if (cnt == '0) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = CW'(GUARD - 1);
            end
            if (rise) drop_inc = drop_inc + 2'd1;
         end
         ST_LV1: begin
            if (start) begin
               cnt_nxt = CW'(LV1_W - 1);
            end else if (cnt == '0) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = CW'(GUARD - 1);
            end
            if (rise) drop_inc = 2'd1;
         end
         default: begin
            if (start) begin
               state_nxt = ST_LV1;
               cnt_nxt   = CW'(LV1_W - 1);
            end else if (cnt == '0) begin
               state_nxt = ST_IDLE;
            end
            if (rise) drop_inc = 2'd1;
         end
      endcase
   end

   assign out_lv1_inhibit = in_live && ((state == ST_LV1) || (|sched[LOOK-1:0]));

   always_ff @(posedge clk) begin
      if (rst) begin
         sched         <= '0;
         state         <= ST_IDLE;
         cnt           <= '0;
         plv1_q        <= 1'b0;
         live_q        <= 1'b0;
         out_lv1_ack   <= 1'b0;
         out_lv1_nack  <= 1'b0;
         out_line      <= 1'b0;
         out_line_lv1  <= 1'b0;
         lv1_rej_cnt   <= '0;
         plv1_drop_cnt <= '0;
         cfg_err       <= 1'b0;
         line_conflict <= 1'b0;
      end else begin
         live_q <= in_live;
         if (!in_live) begin
            sched        <= '0;
            state        <= ST_IDLE;
            cnt          <= '0;
            plv1_q       <= 1'b0;
            out_lv1_ack  <= 1'b0;
            out_lv1_nack <= 1'b0;
            out_line     <= 1'b0;
            out_line_lv1 <= 1'b0;
         end else begin
            sched        <= sched_nxt;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            plv1_q       <= in_plv1;
            out_lv1_ack  <= accept;
            out_lv1_nack <= reject;
            out_line     <= (state_nxt == ST_PLV1) || (state_nxt == ST_LV1);
            out_line_lv1 <= (state_nxt == ST_LV1);
         end
         lv1_rej_cnt   <= (live_clr ? 32'd0 : lv1_rej_cnt) + {31'd0, reject};
         plv1_drop_cnt <= (live_clr ? 32'd0 : plv1_drop_cnt)
                          + (in_live ? {30'd0, drop_inc} : 32'd0);
         cfg_err       <= (live_clr ? 1'b0 : cfg_err) | (in_live && in_lv1_req && bad_dly);
         line_conflict <= (live_clr ? 1'b0 : line_conflict) | (in_live && (drop_inc != 2'd0));
      end
   end

endmodule

// File: tb/tb_trig_line_scheduler.sv
// tb/tb_trig_line_scheduler.sv - scoreboard bench for trig_line_scheduler
module tb_trig_line_scheduler;

   logic        clk = 1'b0;
   logic        rst, in_live, in_plv1, in_lv1_req;
   logic [7:0]  cfg_lv1_delay;
   logic        out_lv1_ack, out_lv1_nack, out_lv1_inhibit, out_line, out_line_lv1;
   logic [31:0] lv1_rej_cnt, plv1_drop_cnt;
   logic        cfg_err, line_conflict;

   trig_line_scheduler dut (
      .clk(clk), .rst(rst), .in_live(in_live), .in_plv1(in_plv1),
      .in_lv1_req(in_lv1_req), .cfg_lv1_delay(cfg_lv1_delay),
      .out_lv1_ack(out_lv1_ack), .out_lv1_nack(out_lv1_nack),
      .out_lv1_inhibit(out_lv1_inhibit), .out_line(out_line),
      .out_line_lv1(out_line_lv1), .lv1_rej_cnt(lv1_rej_cnt),
      .plv1_drop_cnt(plv1_drop_cnt), .cfg_err(cfg_err), .line_conflict(line_conflict)
   );

   always #5 clk = ~clk;

   typedef struct {int at; bit ack;} resp_t;
   typedef struct {int d; bit ack;} vec_t;

   int    n_cmp = 0, n_bad = 0, cyc = 0, exp_rej = 0;
   resp_t resp_q[$];
   int    start_q[$];
   logic  prev_lv1 = 1'b0;
   vec_t  tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic monitor();
      resp_t r;
      bit    found;
      if (out_lv1_ack || out_lv1_nack) begin
         if (resp_q.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
         end else begin
            r = resp_q.pop_front();
            chk("resp_cycle", cyc, r.at);
            chk("resp_ack", out_lv1_ack, r.ack);
            chk("resp_nack", out_lv1_nack, !r.ack);
         end
      end else if (resp_q.size() != 0 && resp_q[0].at <= cyc) begin
         r = resp_q.pop_front();
         chk("resp_missing", 32'd0, 32'd1);
      end
      if (out_line_lv1 && !prev_lv1) begin
         found = 1'b0;
         for (int i = 0; i < start_q.size(); i++) begin
            if (!found && start_q[i] == cyc) begin
               start_q.delete(i);
               found = 1'b1;
            end
         end
         chk("lv1_start_booked", found, 1'b1);
      end
      prev_lv1 = out_line_lv1;
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic req(input int d, input bit ack);
      in_lv1_req    = 1'b1;
      cfg_lv1_delay = 8'(d);
      resp_q.push_back('{cyc + 1, ack});
      if (ack) start_q.push_back(cyc + d);
      else exp_rej++;
      step();
      in_lv1_req = 1'b0;
   endtask

   // plv1 pulse placed at offset p from an lv1 booked 50 cycles out
   task automatic run_mix(input int p);
      int b, s, c;
      logic e_lv1, e_pl;
      b = cyc;
      req(50, 1'b1);
      s = b + 50;
      while (cyc <= s + 6) begin
         c = cyc;
         e_lv1 = (c >= s) && (c <= s + 3);
         e_pl  = (c >= s + p) && (c <= s + p + 2) && (c < s);
         chk("mix_line", out_line, e_lv1 || e_pl);
         chk("mix_line_lv1", out_line_lv1, e_lv1);
         chk("mix_inhibit", out_lv1_inhibit, (c >= s - 5) && (c <= s + 3));
         in_plv1 = (c >= s + p - 1) && (c <= s + p + 1);
         step();
      end
      in_plv1 = 1'b0;
   endtask

   initial begin
      int b;
      tbl[0]  = '{30, 1'b1};  tbl[1]  = '{36, 1'b1};  tbl[2]  = '{40, 1'b0};
      tbl[3]  = '{20, 1'b1};  tbl[4]  = '{255, 1'b1}; tbl[5]  = '{6, 1'b0};
      tbl[6]  = '{7, 1'b1};   tbl[7]  = '{0, 1'b0};   tbl[8]  = '{14, 1'b0};
      tbl[9]  = '{7, 1'b0};   tbl[10] = '{50, 1'b1};  tbl[11] = '{55, 1'b0};
      tbl[12] = '{42, 1'b0};  tbl[13] = '{40, 1'b1};

      rst = 1'b1; in_live = 1'b0; in_plv1 = 1'b0; in_lv1_req = 1'b0; cfg_lv1_delay = 8'd0;
      idle(3);
      chk("rst_line", out_line, 1'b0);
      chk("rst_ack", out_lv1_ack | out_lv1_nack, 1'b0);
      chk("rst_inhibit", out_lv1_inhibit, 1'b0);
      chk("rst_rej_cnt", lv1_rej_cnt, 32'd0);
      chk("rst_drop_cnt", plv1_drop_cnt, 32'd0);
      chk("rst_flags", {cfg_err, line_conflict}, 2'b00);
      rst = 1'b0; in_live = 1'b1;
      idle(5);

      // single lv1: pulse 20..23, guard 24..25
      b = cyc;
      req(20, 1'b1);
      while (cyc <= b + 26) begin
         chk("t1_line", out_line, (cyc - b >= 20) && (cyc - b <= 23));
         chk("t1_line_lv1", out_line_lv1, (cyc - b >= 20) && (cyc - b <= 23));
         step();
      end

      // overlapping booking rejected, one spaced by 7 accepted
      idle(5);
      req(20, 1'b1);
      idle(2);
      req(20, 1'b0);
      chk("t2_rej_cnt", lv1_rej_cnt, 32'd1);
      idle(3);
      req(20, 1'b1);
      idle(30);

      // illegal delay, then minimum delay
      chk("t3_cfg_err_before", cfg_err, 1'b0);
      req(5, 1'b0);
      chk("t3_cfg_err", cfg_err, 1'b1);
      chk("t3_rej_cnt", lv1_rej_cnt, 32'd2);
      req(7, 1'b1);
      idle(12);

      // back-to-back table of requests against window and delay boundaries
      foreach (tbl[i]) req(tbl[i].d, tbl[i].ack);
      chk("tbl_rej_cnt", lv1_rej_cnt, exp_rej);
      idle(260);
      chk("tbl_all_started", start_q.size(), 32'd0);

      // plv1 well ahead of lv1, then plv1 truncated by lv1
      idle(5);
      run_mix(-10);
      chk("t4_drop_cnt", plv1_drop_cnt, 32'd0);
      chk("t4_conflict", line_conflict, 1'b0);
      idle(5);
      run_mix(-2);
      chk("t5_drop_cnt", plv1_drop_cnt, 32'd1);
      chk("t5_conflict", line_conflict, 1'b1);

      // live off mid-pulse with two bookings pending
      idle(10);
      b = cyc;
      req(10, 1'b1);
      req(30, 1'b1);
      req(50, 1'b1);
      idle(8);
      chk("t6_line_on", out_line, 1'b1);
      in_live = 1'b0;
      start_q.delete();
      step();
      chk("t6_line_off", out_line, 1'b0);
      repeat (55) begin
         step();
         if (out_line !== 1'b0) chk("t6_line_stays_off", out_line, 1'b0);
      end
      chk("t6_line_idle", out_line, 1'b0);
      chk("t6_rej_held", lv1_rej_cnt, exp_rej);
      chk("t6_drop_held", plv1_drop_cnt, 32'd1);
      chk("t6_flags_held", {cfg_err, line_conflict}, 2'b11);
      in_live = 1'b1;
      step();
      chk("t6_rej_clr", lv1_rej_cnt, 32'd0);
      chk("t6_drop_clr", plv1_drop_cnt, 32'd0);
      chk("t6_flags_clr", {cfg_err, line_conflict}, 2'b00);
      idle(5);
      chk("end_resp_q", resp_q.size(), 32'd0);
      chk("end_start_q", start_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
